// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- signal bundle between the program-counter sequencer and
// its surroundings (decode, jump-target lookup table, instruction ROM).
//
// Parameters:
//   D  : PC width and lookup-target width
//   CW : retired-instruction counter width
//
// Signals:
//   start, stall, branch_en, branch_idx, rel_mode, halt_req : decode requests
//   link_call, ret                                         : branch-and-link controls
//   lut_addr   : table index driven by the sequencer
//   lut_target : table data returned in the same cycle
//   prog_ctr, running, done, retired, link_addr            : sequencer status
//   dbg_state  : raw FSM state for observation
//
// Handshake semantics: there is no valid/ready pairing on this bundle. Every
// request input is level-sampled on each rising clock edge, and every status
// output is a register that changes only on that edge. The one exception is
// lut_addr, which is a combinational copy of branch_idx.
//
// Modports:
//   master : the sequencer side
//   slave  : the environment side (decode, table, ROM)

interface pc_sequencer_if #(
    parameter int D  = 10,
    parameter int CW = 16
);
    logic          start;
    logic          stall;
    logic          branch_en;
    logic [3:0]    branch_idx;
    logic          rel_mode;
    logic          halt_req;
    logic          link_call;
    logic          ret;
    logic [3:0]    lut_addr;
    logic [D-1:0]  lut_target;
    logic [D-1:0]  prog_ctr;
    logic          running;
    logic          done;
    logic [CW-1:0] retired;
    logic [D-1:0]  link_addr;
    logic [1:0]    dbg_state;

    modport master (
        input  start, stall, branch_en, branch_idx, rel_mode, halt_req,
               link_call, ret, lut_target,
        output lut_addr, prog_ctr, running, done, retired, link_addr, dbg_state
    );

    modport slave (
        output start, stall, branch_en, branch_idx, rel_mode, halt_req,
               link_call, ret, lut_target,
        input  lut_addr, prog_ctr, running, done, retired, link_addr, dbg_state
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer and initiator of the 16-entry
// jump-target lookup table.
//
// Owns the PC register. The branch index is forwarded to the table as
// lut_addr. The returned target is used in the same cycle, either as an
// absolute jump target or as a two's-complement offset added to the PC.
//
// Ports:
//   Clk   : system clock; all state updates happen on its rising edge
//   Reset : synchronous, active-high reset; overrides every other input
//   bus   : pc_sequencer_if.master (decode requests, table index/data,
//           PC and status outputs, dbg_state)
//
// Optional feature:
//   PC_LINK_REG_EN -- when defined, enables the branch-and-link register
//   (link_call saves PC+1; ret jumps back to it). When undefined, link_call
//   and ret are ignored and link_addr reads constant 0.

module pc_sequencer #(
    parameter int D  = 10,
    parameter int CW = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    pc_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q;
    logic [D-1:0]  pc_q;
    logic [CW-1:0] retired_q;
    logic          running_q;
    logic          done_q;
    logic [D-1:0]  next_pc;

    // The table read is combinational: the index goes straight out, and the
    // target comes back within the same cycle.
    assign bus.lut_addr = bus.branch_idx;

`ifdef PC_LINK_REG_EN
    logic [D-1:0] link_q;
`endif

    // Next PC for a RUN cycle that advances. The stall and halt cases are
    // handled in the FSM. Later assignments take priority: ret beats
    // branch_en, which beats the plain increment. In relative mode the
    // modulo-2**D add also handles negative offsets.
    always_comb begin
        next_pc = pc_q + D'(1);
        if (bus.branch_en) begin
            next_pc = bus.rel_mode ? (pc_q + bus.lut_target) : bus.lut_target;
        end
`ifdef PC_LINK_REG_EN
        if (bus.ret) begin
            next_pc = link_q;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            retired_q <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef PC_LINK_REG_EN
            link_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= RUN;
                        pc_q      <= '0;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.halt_req) begin
                        state_q   <= HALT;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (!bus.stall) begin
                        pc_q <= next_pc;
                        // Saturate rather than wrap the retired count.
                        if (retired_q != '1) begin
                            retired_q <= retired_q + CW'(1);
                        end
`ifdef PC_LINK_REG_EN
                        if (bus.branch_en && bus.link_call) begin
                            link_q <= pc_q + D'(1);
                        end
`endif
                    end
                end
                HALT: begin
                    if (bus.start) begin
                        state_q   <= RUN;
                        pc_q      <= '0;
                        retired_q <= '0;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prog_ctr  = pc_q;
    assign bus.retired   = retired_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

`ifdef PC_LINK_REG_EN
    assign bus.link_addr = link_q;
`else
    assign bus.link_addr = '0;
    // link_call and ret have no effect without the link register.
    logic unused_link;
    assign unused_link = bus.link_call ^ bus.ret;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed bench for pc_sequencer. A behavioural model
// tracks the expected PC, counter, link and state. A compare process checks
// every falling edge, and literal pins fix known points of the sequence.
// Build with or without PC_LINK_REG_EN.

module tb_pc_sequencer;
    localparam int D    = 10;
    localparam int CW   = 16;
    localparam int MODV = 1 << D;
    localparam int RMAX = (1 << CW) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   chk_en;

    pc_sequencer_if #(.D(D), .CW(CW)) bus ();

    pc_sequencer #(.D(D), .CW(CW)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- lookup table model ----------------
    logic [D-1:0] lut [16];
    assign bus.lut_target = lut[bus.lut_addr];

`ifdef PC_LINK_REG_EN
    localparam bit LINK_EN = 1'b1;
`else
    localparam bit LINK_EN = 1'b0;
`endif

    // ---------------- behavioural model ----------------
    // m_st: 0 idle, 1 running, 2 halted
    int m_st, m_pc, m_ret, m_link;

    always @(posedge clk) begin
        int n_st, n_pc, n_ret, n_link, tgt;
        n_st = m_st; n_pc = m_pc; n_ret = m_ret; n_link = m_link;
        if (rst) begin
            n_st = 0; n_pc = 0; n_ret = 0; n_link = 0;
        end else if (m_st == 0) begin
            if (bus.start) begin n_st = 1; n_pc = 0; end
        end else if (m_st == 1) begin
            if (bus.halt_req) n_st = 2;
            else if (!bus.stall) begin
                tgt = int'(lut[bus.branch_idx]);
                if (LINK_EN && bus.ret) n_pc = m_link;
                else if (bus.branch_en)
                    n_pc = bus.rel_mode ? (m_pc + tgt) % MODV : tgt;
                else n_pc = (m_pc + 1) % MODV;
                if (LINK_EN && bus.branch_en && bus.link_call)
                    n_link = (m_pc + 1) % MODV;
                n_ret = (m_ret < RMAX) ? m_ret + 1 : RMAX;
            end
        end else begin
            if (bus.start) begin n_st = 1; n_pc = 0; n_ret = 0; end
        end
        m_st <= n_st; m_pc <= n_pc; m_ret <= n_ret; m_link <= n_link;
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("prog_ctr", int'(bus.prog_ctr), m_pc);
            chk("retired", int'(bus.retired), m_ret);
            chk("running", int'(bus.running), (m_st == 1) ? 1 : 0);
            chk("done", int'(bus.done), (m_st == 2) ? 1 : 0);
            chk("link_addr", int'(bus.link_addr), m_link);
            chk("lut_addr", int'(bus.lut_addr), int'(bus.branch_idx));
        end
    end

    // ---------------- driver ----------------
    task automatic idle_inputs();
        bus.start = 0; bus.stall = 0; bus.branch_en = 0; bus.branch_idx = 0;
        bus.rel_mode = 0; bus.halt_req = 0; bus.link_call = 0; bus.ret = 0;
    endtask

    // Apply one cycle of inputs, then let exactly one rising edge consume them.
    task automatic cyc(input bit st, input bit sl, input bit br, input int idx,
                       input bit rel, input bit hl, input bit lc, input bit rt);
        bus.start = st; bus.stall = sl; bus.branch_en = br;
        bus.branch_idx = 4'(idx); bus.rel_mode = rel; bus.halt_req = hl;
        bus.link_call = lc; bus.ret = rt;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic inc();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jmp(input int idx, input bit rel);
        cyc(0, 0, 1, idx, rel, 0, 0, 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        checks = 0; failures = 0; chk_en = 0;
        m_st = 0; m_pc = 0; m_ret = 0; m_link = 0;
        for (int i = 0; i < 16; i++) lut[i] = D'(i * 3);
        lut[1] = 10'h3FF; lut[2] = 10'd9;  lut[3] = 10'd20; lut[4] = 10'h3FF;
        lut[5] = 10'd5;   lut[6] = 10'd40; lut[7] = 10'd4;  lut[8] = 10'd37;
        lut[9] = 10'd12;
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        chk("reset pc", int'(bus.prog_ctr), 0);
        chk("reset running", int'(bus.running), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset retired", int'(bus.retired), 0);
        rst = 0;

        // IDLE ignores branch requests
        jmp(2, 0);
        chk("idle ignores", int'(bus.prog_ctr), 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("start running", int'(bus.running), 1);
        inc(); inc(); inc();
        chk("pc after 3", int'(bus.prog_ctr), 3);

        // relative branch by -1, with a same-cycle lut_addr check
        bus.branch_en = 1; bus.branch_idx = 4'd1; bus.rel_mode = 1;
        #1 chk("lut_addr comb", int'(bus.lut_addr), 1);
        @(posedge clk); #1; idle_inputs();
        chk("rel -1 pc", int'(bus.prog_ctr), 2);
        chk("rel -1 retired", int'(bus.retired), 4);

        jmp(7, 0); chk("abs 4", int'(bus.prog_ctr), 4);
        jmp(2, 0); chk("abs 9", int'(bus.prog_ctr), 9);
        jmp(3, 1); chk("rel 29", int'(bus.prog_ctr), 29);

        // wrap cases
        jmp(4, 0); chk("abs 1023", int'(bus.prog_ctr), 1023);
        inc();     chk("wrap inc", int'(bus.prog_ctr), 0);
        jmp(4, 0);
        jmp(5, 1); chk("wrap rel", int'(bus.prog_ctr), 4);
        chk("retired 11", int'(bus.retired), 11);

        // stall blocks a branch
        cyc(0, 1, 1, 2, 0, 0, 0, 0);
        chk("stall pc", int'(bus.prog_ctr), 4);
        chk("stall retired", int'(bus.retired), 11);

        // reset mid-RUN with a branch pending
        jmp(8, 0); chk("at 37", int'(bus.prog_ctr), 37);
        rst = 1;
        cyc(0, 0, 1, 2, 0, 0, 0, 0);
        rst = 0;
        chk("rst pc", int'(bus.prog_ctr), 0);
        chk("rst running", int'(bus.running), 0);
        chk("rst retired", int'(bus.retired), 0);

        // halt beats stall and branch
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        inc(); inc();
        cyc(0, 1, 1, 2, 0, 1, 0, 0);
        chk("halt done", int'(bus.done), 1);
        chk("halt pc", int'(bus.prog_ctr), 2);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        inc();
        chk("halt frozen", int'(bus.prog_ctr), 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("restart pc", int'(bus.prog_ctr), 0);
        chk("restart retired", int'(bus.retired), 0);
        chk("restart running", int'(bus.running), 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("start in run", int'(bus.prog_ctr), 1);

        // branch-and-link and return
        jmp(9, 0); chk("at 12", int'(bus.prog_ctr), 12);
        cyc(0, 0, 1, 6, 0, 0, 1, 0);
        chk("call pc", int'(bus.prog_ctr), 40);
        chk("call link", int'(bus.link_addr), LINK_EN ? 13 : 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ret pc", int'(bus.prog_ctr), LINK_EN ? 13 : 41);
        // ret beats branch; stall blocks ret
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 2, 0, 0, 0, 1);
        chk("ret vs br", int'(bus.prog_ctr), LINK_EN ? 13 : 9);
        // a link update during a stall must not happen
        cyc(0, 1, 1, 6, 0, 0, 1, 0);
        chk("stall link", int'(bus.link_addr), LINK_EN ? 13 : 0);
        inc(); inc();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
